// File: rtl/rr_grant_ctrl.sv
// Round-robin grant controller for the head of an upstream request queue.
// Holds a one-hot grant until release, timeout or abort, then pops the queue head.
module rr_grant_ctrl #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_i,
    input  logic                 req_valid,
    input  logic [N-1:0]         done_i,
    output logic [N-1:0]         gnt_o,
    output logic [$clog2(N)-1:0] gnt_idx,
    output logic                 pop_o,
    output logic                 timeout_o,
    output logic                 busy
);

    localparam int IW = $clog2(N);
    localparam int HW = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = (HOLD_MAX > 0) ? HW'(HOLD_MAX - 1) : {HW{1'b0}};
    localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        POP   = 2'd2
    } state_t;

    state_t          state_r;
    logic [IW-1:0]   ptr_r;
    logic [HW-1:0]   hold_r;
    logic [N-1:0]    gnt_r;
    logic [IW-1:0]   gnt_idx_r;
    logic            pop_r;
    logic            timeout_r;
    logic            busy_r;

    logic [IW-1:0]   pick_s;
    logic [N-1:0]    pick_onehot_s;
    logic            release_s;
    logic            abort_s;
    logic            expire_s;
    logic [HW-1:0]   hold_inc_s;
    logic [IW-1:0]   ptr_next_s;

    // Round-robin pick: scan from the farthest offset back to ptr so the nearest set bit wins.
    always_comb begin
        logic [IW-1:0] cand;
        cand   = ptr_r;
        pick_s = ptr_r;
        for (int off = N - 1; off >= 0; off--) begin
            cand   = IW'((int'(ptr_r) + off) % N);
            pick_s = req_i[cand] ? cand : pick_s;
        end
    end

    // Release/abort/timeout qualifiers and saturating counter/pointer arithmetic.
    always_comb begin
        pick_onehot_s = {{(N-1){1'b0}}, 1'b1} << pick_s;
        release_s     = done_i[gnt_idx_r];
        abort_s       = !req_valid || (req_i == {N{1'b0}});
        expire_s      = (HOLD_MAX > 0) && (hold_r == HOLD_LAST);
        hold_inc_s    = (hold_r == {HW{1'b1}}) ? hold_r : hold_r + HW'(1);
        ptr_next_s    = (gnt_idx_r == IDX_LAST) ? {IW{1'b0}} : gnt_idx_r + IW'(1);
    end

    // Controller FSM with all outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            ptr_r     <= {IW{1'b0}};
            hold_r    <= {HW{1'b0}};
            gnt_r     <= {N{1'b0}};
            gnt_idx_r <= {IW{1'b0}};
            pop_r     <= 1'b0;
            timeout_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    pop_r     <= 1'b0;
                    timeout_r <= 1'b0;
                    hold_r    <= {HW{1'b0}};
                    if (req_valid && (req_i != {N{1'b0}})) begin
                        gnt_r     <= pick_onehot_s;
                        gnt_idx_r <= pick_s;
                        busy_r    <= 1'b1;
                        state_r   <= GRANT;
                    end else begin
                        gnt_r     <= {N{1'b0}};
                        busy_r    <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                GRANT: begin
                    // Abort outranks release, and release outranks timeout.
                    if (abort_s) begin
                        gnt_r     <= {N{1'b0}};
                        pop_r     <= 1'b0;
                        timeout_r <= 1'b0;
                        busy_r    <= 1'b0;
                        state_r   <= IDLE;
                    end else if (release_s) begin
                        gnt_r     <= {N{1'b0}};
                        pop_r     <= 1'b1;
                        timeout_r <= 1'b0;
                        state_r   <= POP;
                    end else if (expire_s) begin
                        gnt_r     <= {N{1'b0}};
                        hold_r    <= hold_inc_s;
                        pop_r     <= 1'b1;
                        timeout_r <= 1'b1;
                        state_r   <= POP;
                    end else begin
                        hold_r    <= hold_inc_s;
                        pop_r     <= 1'b0;
                        timeout_r <= 1'b0;
                        state_r   <= GRANT;
                    end
                end
                POP: begin
                    ptr_r     <= ptr_next_s;
                    gnt_r     <= {N{1'b0}};
                    pop_r     <= 1'b0;
                    timeout_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    gnt_r     <= {N{1'b0}};
                    pop_r     <= 1'b0;
                    timeout_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign gnt_o     = gnt_r;
    assign gnt_idx   = gnt_idx_r;
    assign pop_o     = pop_r;
    assign timeout_o = timeout_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// Scoreboard bench for rr_grant_ctrl: a transaction-level model predicts each
// cycle's outputs into a queue, and a monitor pops and compares them.
module tb_rr_grant_ctrl;

    localparam int N    = 4;
    localparam int HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req_i = 4'b0000;
    logic       req_valid = 1'b0;
    logic [3:0] done_i = 4'b0000;
    logic [3:0] gnt_o;
    logic [1:0] gnt_idx;
    logic       pop_o;
    logic       timeout_o;
    logic       busy;

    always #5 clk = ~clk;

    rr_grant_ctrl #(.N(N), .HOLD_MAX(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .req_valid(req_valid),
        .done_i(done_i), .gnt_o(gnt_o), .gnt_idx(gnt_idx), .pop_o(pop_o),
        .timeout_o(timeout_o), .busy(busy)
    );

    typedef struct {
        int cyc;
        int gnt;
        int idx;
        int busy;
        int pop;
        int to;
    } exp_t;

    exp_t       exp_q[$];
    int         glog[$];
    int         cyc = 0;
    int         total = 0;
    int         passed = 0;
    bit         mon_en = 1'b1;
    logic [3:0] prev_gnt = 4'b0000;

    // Reference model: who owns the grant, how long it has been held, where the search starts.
    int m_owner = -1;
    int m_held = 0;
    int m_ptr = 0;
    bit m_popping = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int expv);
        total++;
        if (act == expv) passed++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    endtask

    task automatic flag(string name);
        total++;
        $display("FAIL %s: got nothing matching, expected an entry (cycle %0d)", name, cyc);
    endtask

    function automatic int rr_pick(logic [3:0] req);
        for (int k = 0; k < N; k++)
            if (req[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [3:0] own_done();
        if (m_owner >= 0) return 4'(1 << m_owner);
        return 4'b0000;
    endfunction

    task automatic model_step(logic [3:0] req, logic v, logic [3:0] done);
        exp_t e;
        int p = 0;
        int t = 0;
        if (m_popping) begin
            m_ptr = (m_owner + 1) % N;
            m_owner = -1;
            m_popping = 1'b0;
        end else if (m_owner < 0) begin
            if (v && req != 4'b0000) begin
                m_owner = rr_pick(req);
                m_held = 0;
            end
        end else if (!v || req == 4'b0000) begin
            m_owner = -1;
        end else if (done[m_owner]) begin
            m_popping = 1'b1;
            p = 1;
        end else begin
            m_held++;
            if (HOLD > 0 && m_held >= HOLD) begin
                m_popping = 1'b1;
                p = 1;
                t = 1;
            end
        end
        e.cyc  = cyc + 1;
        e.gnt  = (m_owner >= 0 && !m_popping) ? (1 << m_owner) : 0;
        e.idx  = m_owner;
        e.busy = (m_owner >= 0) ? 1 : 0;
        e.pop  = p;
        e.to   = t;
        exp_q.push_back(e);
    endtask

    task automatic drive(logic [3:0] req, logic v, logic [3:0] done);
        @(negedge clk);
        req_i = req;
        req_valid = v;
        done_i = done;
        model_step(req, v, done);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_i = 4'b0000;
        done_i = 4'b0000;
        #1;
        chk("rst_gnt_o", int'(gnt_o), 0);
        chk("rst_gnt_idx", int'(gnt_idx), 0);
        chk("rst_pop_o", int'(pop_o), 0);
        chk("rst_timeout_o", int'(timeout_o), 0);
        chk("rst_busy", int'(busy), 0);
        m_owner = -1;
        m_held = 0;
        m_ptr = 0;
        m_popping = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_step(4'b0000, 1'b0, 4'b0000);
    endtask

    // Monitor: compare every out-of-reset cycle against the predicted entry.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                flag("stale_expectation");
                void'(exp_q.pop_front());
            end
            if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                flag("no_expectation");
            end else begin
                e = exp_q.pop_front();
                chk("gnt_o", int'(gnt_o), e.gnt);
                if (e.gnt != 0) chk("gnt_idx", int'(gnt_idx), e.idx);
                chk("busy", int'(busy), e.busy);
                chk("pop_o", int'(pop_o), e.pop);
                chk("timeout_o", int'(timeout_o), e.to);
            end
            if (gnt_o != 4'b0000 && prev_gnt == 4'b0000) glog.push_back(int'(gnt_idx));
            prev_gnt = gnt_o;
        end else begin
            prev_gnt = 4'b0000;
        end
    end

    initial begin
        int fair_exp[5] = '{0, 1, 2, 3, 0};
        logic [3:0] r;
        logic [3:0] d;
        logic v;

        do_reset();

        // Pointer 0, requests 1010: requester 1 first, then the pointer moves to 2.
        glog.delete();
        drive(4'b1010, 1'b1, 4'b0000);
        drive(4'b1010, 1'b1, own_done());
        drive(4'b1010, 1'b1, 4'b0000);
        drive(4'b1111, 1'b1, 4'b0000);
        drive(4'b1111, 1'b1, own_done());
        drive(4'b0000, 1'b0, 4'b0000);
        @(posedge clk); #2;
        chk("rr_first_count", glog.size(), 2);
        if (glog.size() >= 2) begin
            chk("rr_first_idx", glog[0], 1);
            chk("rr_after_pop_idx", glog[1], 2);
        end

        // Fairness with all requesters active and a two-cycle hold.
        do_reset();
        glog.delete();
        for (int g = 0; g < 5; g++) begin
            drive(4'b1111, 1'b1, 4'b0000);
            drive(4'b1111, 1'b1, 4'b0000);
            drive(4'b1111, 1'b1, own_done());
            drive(4'b1111, 1'b1, 4'b0000);
        end
        @(posedge clk); #2;
        chk("fair_count", glog.size(), 5);
        for (int g = 0; g < 5 && g < glog.size(); g++) chk("fair_order", glog[g], fair_exp[g]);

        // Timeout after HOLD cycles, with other requesters' done bits as noise.
        drive(4'b0100, 1'b1, 4'b0000);
        for (int k = 0; k < HOLD; k++) drive(4'b0100, 1'b1, 4'b1011);
        drive(4'b0100, 1'b1, 4'b0000);

        // Release in the timeout cycle wins.
        drive(4'b0100, 1'b1, 4'b0000);
        for (int k = 0; k < HOLD - 1; k++) drive(4'b0100, 1'b1, 4'b0000);
        drive(4'b0100, 1'b1, own_done());
        drive(4'b0000, 1'b0, 4'b0000);

        // Abort outranks a simultaneous release; pointer stays put.
        drive(4'b0100, 1'b1, 4'b0000);
        drive(4'b0100, 1'b0, own_done());
        drive(4'b1111, 1'b1, 4'b0000);
        drive(4'b0000, 1'b1, 4'b0000);
        drive(4'b0000, 1'b0, 4'b0000);

        // Reset mid-grant, then a fresh grant decided from pointer 0.
        drive(4'b0010, 1'b1, 4'b0000);
        drive(4'b0010, 1'b1, 4'b0000);
        do_reset();
        glog.delete();
        drive(4'b1000, 1'b1, 4'b0000);
        drive(4'b1000, 1'b1, own_done());
        @(posedge clk); #2;
        chk("post_reset_count", glog.size(), 1);
        if (glog.size() >= 1) chk("post_reset_idx", glog[0], 3);

        // Randomized traffic with one reset in the middle.
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            v = ($urandom_range(0, 9) != 0);
            r = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            d = 4'($urandom_range(0, 15)) & ~own_done();
            if ($urandom_range(0, 3) == 0) d = d | own_done();
            drive(r, v, d);
        end
        drive(4'b0000, 1'b0, 4'b0000);
        drive(4'b0000, 1'b0, 4'b0000);
        @(posedge clk); #2;
        mon_en = 1'b0;
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rr_grant_ctrl.md
RR_GRANT_CTRL -- requirements
Module: rr_grant_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the number of requesters (N >= 2).
REQ-002 The block SHALL have parameter HOLD_MAX, default 15, meaning the maximum grant hold in cycles; 0 disables the timeout.
REQ-003 The block SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port req_i, input, N bits: request vector at the upstream queue head.
REQ-006 The block SHALL have port req_valid, input, 1 bit: queue head valid (upstream not empty).
REQ-007 The block SHALL have port done_i, input, N bits: per-requester release; only the granted bit is honoured.
REQ-008 The block SHALL have port gnt_o, output, N bits: registered one-hot grant.
REQ-009 The block SHALL have port gnt_idx, output, $clog2(N) bits: index of the granted requester; valid while gnt_o != 0.
REQ-010 The block SHALL have port pop_o, output, 1 bit: one-cycle pulse to dequeue the upstream head.
REQ-011 The block SHALL have port timeout_o, output, 1 bit: one-cycle pulse when a grant was released by timeout.
REQ-012 The block SHALL have port busy, output, 1 bit: high when the FSM is in any state other than IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, GRANT and POP.
REQ-014 In IDLE, if req_valid=1 and req_i!=0, the block SHALL select a requester, register gnt_o and gnt_idx, and enter GRANT; otherwise it SHALL stay in IDLE with gnt_o=0.
REQ-015 Selection SHALL be round-robin: search indices ptr, ptr+1, ... wrapping modulo N, and take the first set bit of req_i.
REQ-016 Grant latency SHALL be 1 cycle: gnt_o is asserted on the edge that samples the qualifying req_i.
REQ-017 In GRANT, gnt_o and gnt_idx SHALL be held constant.
REQ-018 A hold counter SHALL clear on entry to GRANT and increment on each GRANT cycle in which there is no release.
REQ-019 A release occurs when done_i[gnt_idx]=1; on release the FSM SHALL enter POP.
REQ-020 If HOLD_MAX>0 and the grant has been held HOLD_MAX cycles without a release, the FSM SHALL enter POP and pulse timeout_o for 1 cycle, coincident with pop_o.
REQ-021 If a release and a timeout occur in the same cycle, the release SHALL win and timeout_o SHALL stay 0.
REQ-022 If HOLD_MAX=0, the grant SHALL be held until a release or an abort.
REQ-023 done_i bits other than gnt_idx SHALL be ignored in every state.
REQ-024 In POP, pop_o SHALL be 1 for exactly 1 cycle, gnt_o SHALL be 0, and ptr SHALL become (gnt_idx+1) mod N; the next state SHALL be IDLE unconditionally.
REQ-025 Rationale for POP: the upstream head changes only after the pop edge, so a new selection is made no earlier than the cycle after POP.
REQ-026 Abort: if req_valid=0 or req_i=0 during GRANT, the FSM SHALL return to IDLE next cycle with gnt_o=0, no pop_o and no timeout_o, and ptr unchanged.
REQ-027 Abort SHALL take priority over release and timeout in the same cycle.
REQ-028 pop_o and timeout_o SHALL never assert outside POP.
REQ-029 gnt_o SHALL be one-hot or zero at all times.
REQ-030 The hold counter SHALL be $clog2(HOLD_MAX+1) bits wide (minimum 1 bit) and SHALL never wrap.
REQ-031 ptr SHALL be $clog2(N) bits wide; for N not a power of 2, increment SHALL wrap from N-1 to 0.

Reset
REQ-032 When rst_n=0, the block SHALL asynchronously set state=IDLE, ptr=0, hold counter=0, gnt_o=0, gnt_idx=0, pop_o=0, timeout_o=0 and busy=0.
REQ-033 Reset asserted mid-GRANT or mid-POP SHALL drop the grant immediately with no pop_o pulse.
REQ-034 After rst_n deasserts, the first grant SHALL be decided by ptr=0.

Verification
REQ-035 N=4, ptr=0, req_i=4'b1010 with req_valid=1: gnt_o=4'b0010 one cycle later; after done_i=4'b0010, pop_o pulses and ptr=2.
REQ-036 Fairness: req_i=4'b1111 held, each grant released after 2 cycles: grants occur in order 0001, 0010, 0100, 1000, 0001.
REQ-037 HOLD_MAX=4, no done_i: the grant is held 4 cycles, then pop_o=1 and timeout_o=1 together for 1 cycle.
REQ-038 done_i[gnt_idx] asserted in the timeout cycle: pop_o=1 and timeout_o=0.
REQ-039 req_valid drops during GRANT: gnt_o=0 next cycle, pop_o never pulses, ptr unchanged.
REQ-040 rst_n asserted during GRANT: gnt_o=0 immediately; after release, req_i=4'b1000 gives gnt_o=4'b1000.
